// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: opcode/subcode constants and divider FSM states shared by vec_alu
package vec_alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_MEM4 = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_MEMC = 4'hC;
  localparam logic [3:0] OP_MEMD = 4'hD;
  localparam logic [3:0] OP_DOT  = 4'hE;
  localparam logic [3:0] SUB_LD  = 4'h0;
  localparam logic [3:0] SUB_ST  = 4'h1;
  localparam logic [3:0] SUB_JZ  = 4'h0;
  localparam logic [3:0] SUB_JNZ = 4'h1;
  localparam logic [3:0] SUB_JS  = 4'h2;
  localparam logic [3:0] SUB_JNS = 4'h3;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
  function automatic logic is_mem(input logic [3:0] op);
    return op == OP_MEM4 || op == OP_MEMC || op == OP_MEMD;
  endfunction
endpackage

// File: rtl/vec_alu_divider.sv
// vec_alu_divider: single-lane restoring divider, one quotient bit per cycle
module vec_alu_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, src_rem, src_quo, src_dvs, rem_n, quo_n;
  logic [WIDTH:0] trial;
  logic ge;
  // the first step is taken on the start edge itself, straight from the operands
  assign src_rem = start ? '0 : rem;
  assign src_quo = start ? dividend : quo;
  assign src_dvs = start ? divisor : dvs;
  assign trial = {src_rem, src_quo[WIDTH-1]};
  assign ge = trial >= {1'b0, src_dvs};
  assign rem_n = ge ? WIDTH'(trial - {1'b0, src_dvs}) : trial[WIDTH-1:0];
  assign quo_n = WIDTH'({src_quo, ge});
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH - 1);
      rem <= rem_n;
      quo <= quo_n;
      dvs <= divisor;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      rem <= rem_n;
      quo <= quo_n;
    end
  assign done = cnt == '0;
  assign quotient = quo;
  assign div_zero = dvs == '0;
endmodule

// File: rtl/vec_alu.sv
// vec_alu: two-stage multi-lane ALU with iterative divide, dot product, jumps and load/store
module vec_alu
  import vec_alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LANES   = 4,
  parameter int PC_STEP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_pc,
  input  logic [15:0]            in_ins,
  input  logic [LANES*WIDTH-1:0] in_op1,
  input  logic [LANES*WIDTH-1:0] in_op2,
  input  logic [LANES*WIDTH-1:0] mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic                   out_take_jump,
  output logic [LANES-1:0]       out_overflow
);
  localparam int VW = LANES * WIDTH;
  logic s1_valid, s1_done, s1_advance, accept, start, s2_valid, take, jmp_take, unused_ins;
  logic [3:0] s1_opc, s1_sub;
  logic [WIDTH-1:0] s1_pc, dot, jmp_tgt;
  logic [VW-1:0] s1_op1, s1_op2, alu_res, res;
  logic [LANES-1:0] alu_ovf, div_done, ovf;
  logic [WIDTH-1:0] prod_lo [LANES];
  div_state_t state;
  assign unused_ins = ^{in_ins[11:8], in_ins[3:0]};
  assign accept = in_valid && in_ready;
  assign start = accept && in_ins[15:12] == OP_DIV;
  assign s1_done = s1_opc != OP_DIV || state == DIV_DONE;
  assign s1_advance = s1_valid && s1_done && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s1_advance;
  assign out_valid = s2_valid;
  // a new divide may start on the same edge the finished one leaves S1
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= DIV_IDLE;
    else if (start) state <= DIV_BUSY;
    else if (state == DIV_BUSY && &div_done) state <= DIV_DONE;
    else if (state == DIV_DONE && s1_advance) state <= DIV_IDLE;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0] a, b, quo;
    logic [WIDTH:0] sum, dif;
    logic [2*WIDTH-1:0] prod;
    logic dz;
    assign a = s1_op1[l*WIDTH +: WIDTH];
    assign b = s1_op2[l*WIDTH +: WIDTH];
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign prod_lo[l] = prod[WIDTH-1:0];
    vec_alu_divider #(.WIDTH(WIDTH)) u_div (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(in_op1[l*WIDTH +: WIDTH]),
      .divisor(in_op2[l*WIDTH +: WIDTH]),
      .done(div_done[l]),
      .quotient(quo),
      .div_zero(dz)
    );
    assign alu_res[l*WIDTH +: WIDTH] = s1_opc == OP_ADD ? sum[WIDTH-1:0] :
                                       s1_opc == OP_SUB ? dif[WIDTH-1:0] :
                                       s1_opc == OP_MUL ? prod[WIDTH-1:0] : quo;
    assign alu_ovf[l] = s1_opc == OP_ADD ? sum[WIDTH] :
                        s1_opc == OP_SUB ? dif[WIDTH] :
                        s1_opc == OP_MUL ? |prod[2*WIDTH-1:WIDTH] : dz;
  end
  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) dot = dot + prod_lo[i];
  end
  assign jmp_take = s1_sub == SUB_JZ  ? s1_op1[WIDTH-1:0] == '0 :
                    s1_sub == SUB_JNZ ? |s1_op1[WIDTH-1:0] :
                    s1_sub == SUB_JS  ? s1_op1[WIDTH-1] :
                    s1_sub == SUB_JNS ? !s1_op1[WIDTH-1] : 1'b0;
  assign jmp_tgt = jmp_take ? s1_op2[WIDTH-1:0] : s1_pc + WIDTH'(PC_STEP);
  always_comb begin
    res = '0;
    ovf = '0;
    take = 1'b0;
    if (s1_opc inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV}) begin
      res = alu_res;
      ovf = alu_ovf;
    end else if (s1_opc == OP_DOT) res[WIDTH-1:0] = dot;
    else if (s1_opc == OP_JMP) begin
      res[WIDTH-1:0] = jmp_tgt;
      take = jmp_take;
    end else if (is_mem(s1_opc) && s1_sub == SUB_ST) res = s1_op1;
    else if (s1_opc == OP_LD || (is_mem(s1_opc) && s1_sub == SUB_LD)) res = mem_rdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_opc <= '0;
      s1_sub <= '0;
      s1_pc <= '0;
      s1_op1 <= '0;
      s1_op2 <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_opc <= in_ins[15:12];
      s1_sub <= in_ins[7:4];
      s1_pc <= in_pc;
      s1_op1 <= in_op1;
      s1_op2 <= in_op2;
    end else if (s1_advance) s1_valid <= 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s2_valid <= 1'b0;
      out_result <= '0;
      out_take_jump <= 1'b0;
      out_overflow <= '0;
    end else if (s1_advance) begin
      s2_valid <= 1'b1;
      out_result <= res;
      out_take_jump <= take;
      out_overflow <= ovf;
    end else if (out_ready) s2_valid <= 1'b0;
endmodule

// File: tb/tb_vec_alu.sv
// tb_vec_alu: table-driven scoreboard bench for vec_alu plus stall, divide and reset sequences
module tb_vec_alu;
  localparam int W = 16;
  localparam int L = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_take_jump;
  logic [W-1:0] in_pc = '0;
  logic [15:0] in_ins = '0;
  logic [L*W-1:0] in_op1 = '0, in_op2 = '0, mem_rdata = '0, out_result;
  logic [L-1:0] out_overflow;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, lat = 0, outs = 0;
  typedef struct packed {logic [63:0] res; logic jmp; logic [3:0] ovf;} exp_t;
  typedef struct {logic [15:0] ins; logic [15:0] pc; logic [63:0] op1, op2, mem; exp_t e;} vec_t;
  exp_t sb[$];
  exp_t me;
  vec_t vt[22];

  vec_alu #(.WIDTH(W), .LANES(L), .PC_STEP(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_ins(in_ins), .in_op1(in_op1), .in_op2(in_op2), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_take_jump(out_take_jump), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pk(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mkv(input logic [15:0] ins, pc, input logic [63:0] a, b, m, r,
                               input logic j, input logic [3:0] o);
    vec_t v;
    v.ins = ins; v.pc = pc; v.op1 = a; v.op2 = b; v.mem = m;
    v.e.res = r; v.e.jmp = j; v.e.ovf = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk)
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got=%h exp=none", out_result);
      end else begin
        me = sb.pop_front();
        chk("result", out_result, me.res);
        chk("take_jump", 64'(out_take_jump), 64'(me.jmp));
        chk("overflow", 64'(out_overflow), 64'(me.ovf));
        lat = cyc - acc_cyc;
        outs++;
      end
    end

  task automatic send(input vec_t v);
    int n = 0;
    in_ins = v.ins; in_pc = v.pc; in_op1 = v.op1; in_op2 = v.op2; mem_rdata = v.mem;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=in_ready0 exp=in_ready1");
    end else begin
      sb.push_back(v.e);
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain_timeout pending=%0d exp=0", nm, sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t a_v, b_v, c_v, d_v;
    int n, seen, outs0;
    vt[0]  = mkv(16'h0000, 16'h0, pk(1, 2, 16'hFFFF, 5), pk(1, 2, 1, 5), '0, pk(2, 4, 0, 10), 1'b0, 4'b0100);
    vt[1]  = mkv(16'h1000, 16'h0, pk(5, 0, 10, 16'hFFFF), pk(3, 1, 10, 1), '0, pk(2, 16'hFFFF, 0, 16'hFFFE), 1'b0, 4'b0010);
    vt[2]  = mkv(16'h2000, 16'h0, pk(3, 16'h100, 16'hFFFF, 7), pk(4, 16'h100, 2, 0), '0, pk(12, 0, 16'hFFFE, 0), 1'b0, 4'b0110);
    vt[3]  = mkv(16'h3000, 16'h0, pk(100, 7, 9, 0), pk(7, 100, 3, 0), '0, pk(14, 0, 3, 16'hFFFF), 1'b0, 4'b1000);
    vt[4]  = mkv(16'hE000, 16'h0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), '0, pk(70, 0, 0, 0), 1'b0, 4'b0000);
    vt[5]  = mkv(16'hE000, 16'h0, pk(16'hFFFF, 2, 0, 0), pk(16'hFFFF, 16'h8000, 0, 0), '0, pk(1, 0, 0, 0), 1'b0, 4'b0000);
    vt[6]  = mkv(16'h6000, 16'h10, pk(0, 5, 5, 5), pk(16'h40, 7, 7, 7), '0, pk(16'h40, 0, 0, 0), 1'b1, 4'b0000);
    vt[7]  = mkv(16'h6000, 16'h10, pk(3, 0, 0, 0), pk(16'h40, 7, 7, 7), '0, pk(16'h12, 0, 0, 0), 1'b0, 4'b0000);
    vt[8]  = mkv(16'h6010, 16'h10, pk(3, 0, 0, 0), pk(16'h40, 7, 7, 7), '0, pk(16'h40, 0, 0, 0), 1'b1, 4'b0000);
    vt[9]  = mkv(16'h6010, 16'h10, pk(0, 9, 9, 9), pk(16'h40, 7, 7, 7), '0, pk(16'h12, 0, 0, 0), 1'b0, 4'b0000);
    vt[10] = mkv(16'h6020, 16'h10, pk(16'h8000, 0, 0, 0), pk(16'h40, 7, 7, 7), '0, pk(16'h40, 0, 0, 0), 1'b1, 4'b0000);
    vt[11] = mkv(16'h6030, 16'h10, pk(16'h8000, 0, 0, 0), pk(16'h40, 7, 7, 7), '0, pk(16'h12, 0, 0, 0), 1'b0, 4'b0000);
    vt[12] = mkv(16'h6030, 16'h10, pk(16'h7FFF, 0, 0, 0), pk(16'h40, 7, 7, 7), '0, pk(16'h40, 0, 0, 0), 1'b1, 4'b0000);
    vt[13] = mkv(16'h6050, 16'h10, pk(0, 0, 0, 0), pk(16'h40, 7, 7, 7), '0, pk(16'h12, 0, 0, 0), 1'b0, 4'b0000);
    vt[14] = mkv(16'h6000, 16'hFFFF, pk(1, 0, 0, 0), pk(16'h40, 0, 0, 0), '0, pk(1, 0, 0, 0), 1'b0, 4'b0000);
    vt[15] = mkv(16'h4010, 16'h0, pk(16'hA, 16'hB, 16'hC, 16'hD), pk(1, 1, 1, 1), pk(9, 9, 9, 9), pk(16'hA, 16'hB, 16'hC, 16'hD), 1'b0, 4'b0000);
    vt[16] = mkv(16'hC010, 16'h0, pk(16'h11, 16'h22, 16'h33, 16'h44), '0, pk(9, 9, 9, 9), pk(16'h11, 16'h22, 16'h33, 16'h44), 1'b0, 4'b0000);
    vt[17] = mkv(16'h7000, 16'h0, pk(5, 5, 5, 5), '0, pk(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), pk(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), 1'b0, 4'b0000);
    vt[18] = mkv(16'hD000, 16'h0, pk(5, 5, 5, 5), '0, pk(16'hCAFE, 0, 1, 2), pk(16'hCAFE, 0, 1, 2), 1'b0, 4'b0000);
    vt[19] = mkv(16'h5000, 16'h0, pk(5, 6, 7, 8), pk(1, 1, 1, 1), pk(3, 3, 3, 3), '0, 1'b0, 4'b0000);
    vt[20] = mkv(16'h4020, 16'h0, pk(5, 6, 7, 8), pk(1, 1, 1, 1), pk(3, 3, 3, 3), '0, 1'b0, 4'b0000);
    vt[21] = mkv(16'hF000, 16'h0, pk(16'hFFFF, 6, 7, 8), pk(16'hFFFF, 1, 1, 1), pk(3, 3, 3, 3), '0, 1'b0, 4'b0000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_result", out_result, 64'(0));
    chk("rst_overflow", 64'(out_overflow), 64'(0));
    chk("rst_take_jump", 64'(out_take_jump), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      send(vt[i]);
      drain($sformatf("vec%0d", i));
    end

    send(vt[0]);
    drain("add_lat");
    chk("add_latency", 64'(lat), 64'(2));

    send(vt[3]);
    @(negedge clk);
    chk("div_busy_in_ready_a", 64'(in_ready), 64'(0));
    repeat (8) @(negedge clk);
    chk("div_busy_in_ready_b", 64'(in_ready), 64'(0));
    chk("div_busy_out_valid", 64'(out_valid), 64'(0));
    drain("div_lat");
    chk("div_latency", 64'(lat), 64'(18));

    a_v = mkv(16'h0000, 16'h0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), '0, pk(2, 2, 2, 2), 1'b0, 4'b0000);
    b_v = mkv(16'h0000, 16'h0, pk(10, 20, 30, 40), pk(1, 1, 1, 1), '0, pk(11, 21, 31, 41), 1'b0, 4'b0000);
    c_v = mkv(16'h0000, 16'h0, pk(16'hFFFF, 16'hFFFF, 3, 4), pk(1, 2, 3, 4), '0, pk(0, 1, 6, 8), 1'b0, 4'b0011);
    outs0 = outs;
    out_ready = 1'b0;
    fork
      begin
        send(a_v);
        send(b_v);
        send(c_v);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 3; k++) begin
          chk("stall_out_valid", 64'(out_valid), 64'(1));
          chk("stall_hold_result", out_result, a_v.e.res);
          chk("stall_in_ready", 64'(in_ready), 64'(0));
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("b2b");
    chk("b2b_output_count", 64'(outs - outs0), 64'(3));

    d_v = vt[3];
    send(d_v);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_output", 64'(seen), 64'(0));
    @(posedge clk);
    #1;
    send(vt[1]);
    drain("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vec_alu.md
VEC_ALU -- requirements
Module: vec_alu

Interface
REQ-001 Parameter WIDTH, default 16, lane data width in bits.
REQ-002 Parameter LANES, default 4, number of parallel lanes; LANES=1 gives scalar behaviour.
REQ-003 Parameter PC_STEP, default 2, increment applied to the PC for a not-taken jump.
REQ-004 clk  in  1  the single clock; all state is updated on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  an instruction and its operands are presented.
REQ-007 in_ready  out  1  the block accepts the presented instruction this cycle.
REQ-008 in_pc  in  WIDTH  PC of the presented instruction.
REQ-009 in_ins  in  16  instruction word; opcode=[15:12], subcode=[7:4].
REQ-010 in_op1, in_op2  in  LANES*WIDTH  operands; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-011 mem_rdata  in  LANES*WIDTH  load data returned for the instruction currently in S1.
REQ-012 out_valid  out  1  the result is valid.
REQ-013 out_ready  in  1  the consumer accepts the result.
REQ-014 out_result  out  LANES*WIDTH  per-lane result.
REQ-015 out_take_jump  out  1  the jump is taken.
REQ-016 out_overflow  out  LANES  per-lane overflow/exception flag.

Function
REQ-017 Pipeline stages: S1 captures on in_valid&&in_ready; S2 holds the result and drives the outputs; latency is 2 cycles for non-divide operations with no backpressure.
REQ-018 in_ready = !s1_valid || s1_advance; s1_advance = s1_valid && s1_done && (!s2_valid || out_ready); simultaneous accept and advance is required to give 1-per-cycle throughput.
REQ-019 S2 holds its contents stable while out_valid && !out_ready.
REQ-020 Operations per lane, all modulo 2^WIDTH:
- opcode 0000 add; overflow = carry out.
- opcode 0001 sub; overflow = borrow.
- opcode 0010 mul; result = low half; overflow = high half nonzero.
- opcode 0011 unsigned divide.
REQ-021 Opcode 1110 (dot) SHALL produce lane 0 = sum over lanes of op1*op2 (truncated), all other lanes 0, and overflow 0.
REQ-022 Opcode 0110 (jump) tests op1 lane 0:
- subcode 0 jz: lane0 == 0.
- subcode 1 jnz: lane0 != 0.
- subcode 2 js: lane0[WIDTH-1] == 1.
- subcode 3 jns: lane0[WIDTH-1] == 0.
- Result lane 0 = taken ? op2 lane0 : pc+PC_STEP; other lanes 0; out_take_jump = taken.
- Subcodes 4..15 give not-taken.
REQ-023 Store (opcode 0100/1100/1101 with subcode 1) SHALL produce result = op1.
REQ-024 Load (opcode 0111, or 0100/1100/1101 with subcode 0) SHALL produce result = mem_rdata, sampled in the cycle s1_advance is high.
REQ-025 Any other opcode SHALL produce result 0, take_jump 0, overflow 0.
REQ-026 Divide SHALL be an iterative restoring divider using all lanes in parallel, with FSM states IDLE, BUSY, DONE:
- IDLE->BUSY when a divide is captured in S1.
- BUSY holds for WIDTH cycles, then ->DONE.
- DONE->IDLE on s1_advance.
- s1_done is low in IDLE-with-divide and in BUSY.
- Divide latency is WIDTH+2 cycles.
REQ-027 Divide by zero SHALL give quotient all-ones and overflow 1 for that lane only; the other lanes are unaffected.

Reset
REQ-028 Reset SHALL clear s1_valid, s2_valid, out_valid, out_take_jump, out_overflow and out_result to 0, and set the FSM to IDLE.
REQ-029 in_ready SHALL be 1 immediately after reset.
REQ-030 Reset asserted mid-divide SHALL abort the operation with no output produced.

Structure
REQ-031 Package vec_alu_pkg SHALL hold the opcode and subcode constants and the divider state enum.
REQ-032 One sub-module, vec_alu_divider (single-lane iterative divider, WIDTH parameter, start/done handshake), SHALL be instantiated LANES times.

Verification
REQ-033 add, lanes {1,2,0xFFFF,5} + {1,2,1,5}, out_ready=1 -> out_valid 2 cycles later; result {2,4,0,10}; overflow 0b0100.
REQ-034 div, {100,7,9,0} / {7,100,3,0} -> out_valid after 18 cycles; result {14,0,3,0xFFFF}; overflow 0b1000; in_ready low during BUSY.
REQ-035 jz, pc=0x0010, op1 lane0=0, op2 lane0=0x0040 -> result lane0 0x0040, take_jump 1; with op1 lane0=3 -> 0x0012, take_jump 0.
REQ-036 dot, {1,2,3,4}·{5,6,7,8} -> lane0 70, other lanes 0.
REQ-037 Back-to-back adds with out_ready held low for 3 cycles -> no result lost or duplicated; outputs stable while stalled; in_ready low once S1 and S2 are full.
REQ-038 rst pulsed at cycle 5 of a divide -> out_valid stays 0 and in_ready = 1 after release.
